// File: rtl/demux8_pkg.sv
// Shared definitions for the 8-way write-back demux: select width, destination
// count, default word size, the FIFO entry layout and a one-hot helper.
package demux8_pkg;
  localparam int SEL_W    = 3;
  localparam int NUM_DST  = 8;
  localparam int SIZE_DEF = 16;

  // Entry layout at the default width; the top rebuilds it for other SIZE values
  typedef struct packed {
    logic [SEL_W-1:0]    sel;
    logic [SIZE_DEF-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_DST-1:0] onehot8(input logic [SEL_W-1:0] sel);
    onehot8 = 8'b1 << sel;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// In-order request buffer. The head entry is visible combinationally so it can
// be consumed on the same edge it is popped.
module wb_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;

  // Storage has no reset: contents are only observed while the count covers them
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rdata = mem_q[rptr_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/demux8_wb.sv
// 8-way registered write demux: buffered valid/ready requests drain one per
// cycle into a destination register, announced by a one-hot strobe.
module demux8_wb
  import demux8_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [SIZE-1:0]  in_data,
  input  logic             clear,
  input  logic             hold_drain,
  output logic [SIZE-1:0]  out0,
  output logic [SIZE-1:0]  out1,
  output logic [SIZE-1:0]  out2,
  output logic [SIZE-1:0]  out3,
  output logic [SIZE-1:0]  out4,
  output logic [SIZE-1:0]  out5,
  output logic [SIZE-1:0]  out6,
  output logic [SIZE-1:0]  out7,
  output logic [NUM_DST-1:0] out_strb,
  output logic [CW-1:0]    fifo_cnt
);
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [SIZE-1:0]  data;
  } entry_t;

  entry_t                          head;
  logic                            push, pop, full, empty;
  logic [NUM_DST-1:0][SIZE-1:0]    dst_q, dst_d;
  logic [NUM_DST-1:0]              strb_q, strb_d;

  assign in_ready = ~full & ~clear & rst_n;
  assign push     = in_valid & in_ready;
  // hold_drain is a verification hook that freezes the drain to exercise backpressure
  assign pop      = ~empty & ~clear & ~hold_drain;

  wb_fifo #(.W(SEL_W + SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (clear),
    .wdata ({in_sel, in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  always_comb begin
    dst_d  = dst_q;
    strb_d = '0;
    if (clear) begin
      dst_d = '0;
    end else if (pop) begin
      dst_d[head.sel] = head.data;
      strb_d          = onehot8(head.sel);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst_q  <= '0;
      strb_q <= '0;
    end else begin
      dst_q  <= dst_d;
      strb_q <= strb_d;
    end
  end

  assign out0     = dst_q[0];
  assign out1     = dst_q[1];
  assign out2     = dst_q[2];
  assign out3     = dst_q[3];
  assign out4     = dst_q[4];
  assign out5     = dst_q[5];
  assign out6     = dst_q[6];
  assign out7     = dst_q[7];
  assign out_strb = strb_q;
endmodule

// File: doc/demux8_wb.md
Name: demux8_wb

Overview:
- Write-side counterpart of the 8:1 read-select mux in the register datapath.
- Accepts write requests (3-bit destination select plus data) over a valid/ready handshake.
- Buffers them in a small in-order FIFO and drains one per cycle into one of eight registered outputs.
- Each update is signalled with a one-hot strobe, so downstream logic sees which destination changed.

Parameters:
- SIZE, 16, data width of each input and output word.
- DEPTH, 2, request FIFO entries (power of two, >=2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  write request present.
- in_ready  output  1  block can accept a request this cycle.
- in_sel  input  3  destination index 0..7.
- in_data  input  SIZE  write data.
- clear  input  1  synchronous flush-and-zero command.
- out0..out7  output  SIZE each  registered destination words.
- out_strb  output  8  one-hot pulse: bit k high for exactly the cycle in which outk first shows newly written data.
- fifo_cnt  output  $clog2(DEPTH)+1  current FIFO occupancy (debug/verification).

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at a clock edge): out0..out7=0, out_strb=0, FIFO empty, fifo_cnt=0.
  - in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Handshake:
  - A request is accepted at an edge where in_valid & in_ready.
  - in_ready = (fifo_cnt < DEPTH) & ~clear & rst_n, combinational from registered count.
  - in_sel/in_data are sampled only on acceptance.
  - A producer may hold in_valid with changing data while in_ready=0; nothing is captured.
- Drain:
  - Every cycle the FIFO is non-empty, the head entry is popped at the clock edge.
  - The register selected by the entry is loaded with its data.
  - out_strb is set to one-hot(sel) at that same edge, and all other bits are 0.
  - out_strb is 0 in any cycle following an edge with no pop.
- Latency:
  - Request accepted at edge E into an empty FIFO: popped at edge E+1.
  - outk shows the new data and out_strb[k]=1 in the cycle after E+1.
  - Sustained throughput is 1 write per cycle.
- Simultaneous push and pop in the same edge: count unchanged, order preserved.
  - This covers the full case, since a pop frees a slot only for the next cycle; in_ready is still derived from the pre-edge count.
- Ordering:
  - Strictly FIFO.
  - Consecutive writes to the same index both update; the last one wins.
  - out_strb pulses on both cycles.
- Wrap-around: read/write pointers are log2(DEPTH) bits and wrap naturally. A 1-bit-wider count distinguishes full from empty.
- clear=1 at an edge, with priority over push and pop:
  - FIFO is flushed and count=0.
  - out0..out7=0 and out_strb=0.
  - Any request presented that cycle is not accepted (in_ready=0).
- Reset mid-drain: pending entries are discarded and none reach the outputs.
- Non-selected outputs hold their value; no tri-state or z is ever driven.
- All outputs except in_ready come directly from flops.

Decomposition:
- Shared package demux8_pkg:
  - SEL_W=3, NUM_DST=8, default SIZE=16.
  - Function onehot8(sel), which returns 8-bit one-hot.
  - Type for a FIFO entry {sel, data}.
- One natural sub-module: wb_fifo.
  - Parameterised synchronous FIFO (width SEL_W+SIZE, DEPTH).
  - Ports: push, pop, flush, full, empty, count.
- The top level holds the eight destination registers and the strobe flop.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out0..7=0, out_strb=0, in_ready=0. After release, in_ready=1 and fifo_cnt=0.
- Single write: sel=5, data=16'hBEEF accepted at edge E -> two cycles later out5=16'hBEEF, out_strb=8'b0010_0000 for one cycle, all other outputs unchanged.
- Back-to-back sweep: in_valid held high with sel=0..7 and data=16'h1000+sel on successive cycles.
  - in_ready stays 1 throughout.
  - out_strb walks 8'h01 to 8'h80 on consecutive cycles.
  - Final outk=16'h1000+k.
- Same-destination ordering: writes to sel=3 with data A1A1, then B2B2, on consecutive cycles -> out3 shows A1A1 then B2B2, and out_strb[3] is high for 2 consecutive cycles.
- Full/backpressure (DEPTH=2): a test-only hook holds pop=0 (drain-disable) to fill the FIFO.
  - After 2 acceptances, in_ready=0 and fifo_cnt=2.
  - A third request is held until a pop occurs and is then accepted, with no loss or duplication.
- Clear mid-operation: two entries queued and out2=16'h0055, then pulse clear=1 -> next cycle all outputs are 0, fifo_cnt=0, no strobe, and the queued entries never appear.
